// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
package irq_pkg;

    localparam int NIRQ_DEFAULT = 7;
    localparam int VECW_DEFAULT = 3;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // Encoding is visible to software through the STATUS register.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ISR  = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-first priority encoder returning index+1
module irq_prio_enc #(
    parameter int N = 7,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] vec
);

    always_comb begin
        valid = |req;
        vec   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vec = W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - masked edge/level interrupt controller with req/ack/eoi handshake
module irq_controller
    import irq_pkg::*;
#(
    parameter int NIRQ = NIRQ_DEFAULT,
    parameter int VECW = VECW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            cfg_we,
    input  logic [1:0]      cfg_addr,
    input  logic [15:0]     cfg_din,
    output logic [15:0]     cfg_dout,
    output logic            cpu_irq,
    output logic [VECW-1:0] cpu_vec,
    input  logic            cpu_ack,
    input  logic            cpu_eoi
);

    logic [NIRQ-1:0] mask_q;
    logic [NIRQ-1:0] mode_q;
    logic [NIRQ-1:0] pending_q;
    logic [NIRQ-1:0] prev_q;
    logic [NIRQ-1:0] cur_sel_q;
    irq_state_t      state_q;

    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] enc_onehot;
    logic [NIRQ-1:0] edge_set;
    logic [NIRQ-1:0] ack_clr;
    logic [NIRQ-1:0] clr;
    logic [NIRQ-1:0] pending_nxt;
    logic            enc_valid;
    logic [VECW-1:0] enc_vec;
    logic            withdraw;
    logic            do_ack;
    logic            wr_mask;
    logic            wr_mode;
    logic            wr_pend;
    logic [15:0]     rd_data;
    logic            unused_din;

    assign eligible   = pending_q & ~mask_q;
    assign wr_mask    = cfg_we && (cfg_addr == REG_MASK);
    assign wr_mode    = cfg_we && (cfg_addr == REG_MODE);
    assign wr_pend    = cfg_we && (cfg_addr == REG_PENDING);
    assign unused_din = ^cfg_din;

    irq_prio_enc #(
        .N (NIRQ),
        .W (VECW)
    ) u_prio_enc (
        .req   (eligible),
        .valid (enc_valid),
        .vec   (enc_vec)
    );

    always_comb begin
        enc_onehot = '0;
        for (int i = 0; i < NIRQ; i++) begin
            enc_onehot[i] = (enc_vec == VECW'(i + 1));
        end
        // The latched source is withdrawn once it is no longer both pending and unmasked.
        withdraw    = (state_q == REQ) && !(|(cur_sel_q & eligible));
        do_ack      = (state_q == REQ) && !withdraw && cpu_ack;
        ack_clr     = do_ack ? (cur_sel_q & ~mode_q) : '0;
        edge_set    = irq_in & ~prev_q;
        clr         = (wr_pend ? cfg_din[NIRQ-1:0] : '0) | ack_clr;
        pending_nxt = (mode_q & irq_in) | (~mode_q & (edge_set | (pending_q & ~clr)));
    end

    always_comb begin
        rd_data = '0;
        case (cfg_addr)
            REG_MASK:    rd_data[NIRQ-1:0] = mask_q;
            REG_PENDING: rd_data[NIRQ-1:0] = pending_q;
            REG_MODE:    rd_data[NIRQ-1:0] = mode_q;
            REG_STATUS: begin
                rd_data[VECW+2]      = (state_q != IDLE);
                rd_data[VECW+1 -: 2] = state_q;
                rd_data[VECW-1:0]    = (state_q == ISR) ? cpu_vec : '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q    <= '1;
            mode_q    <= '0;
            pending_q <= '0;
            prev_q    <= '0;
            cfg_dout  <= '0;
        end else begin
            prev_q    <= irq_in;
            pending_q <= pending_nxt;
            cfg_dout  <= rd_data;
            if (wr_mask) begin
                mask_q <= cfg_din[NIRQ-1:0];
            end
            if (wr_mode) begin
                mode_q <= cfg_din[NIRQ-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cpu_irq   <= 1'b0;
            cpu_vec   <= '0;
            cur_sel_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enc_valid) begin
                        cpu_vec   <= enc_vec;
                        cur_sel_q <= enc_onehot;
                        cpu_irq   <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (withdraw) begin
                        cpu_irq <= 1'b0;
                        cpu_vec <= '0;
                        state_q <= IDLE;
                    end else if (cpu_ack) begin
                        cpu_irq <= 1'b0;
                        state_q <= ISR;
                    end
                end
                ISR: begin
                    if (cpu_eoi) begin
                        cpu_vec <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed and randomized checks of irq_controller against a behavioural model
module tb_irq_controller;
    import irq_pkg::*;

    localparam int NIRQ = 7;
    localparam int VECW = 3;
    localparam int ALL  = (1 << NIRQ) - 1;

    logic            clk      = 1'b0;
    logic            rst      = 1'b0;
    logic [NIRQ-1:0] irq_in   = '0;
    logic            cfg_we   = 1'b0;
    logic [1:0]      cfg_addr = 2'd0;
    logic [15:0]     cfg_din  = 16'd0;
    logic [15:0]     cfg_dout;
    logic            cpu_irq;
    logic [VECW-1:0] cpu_vec;
    logic            cpu_ack  = 1'b0;
    logic            cpu_eoi  = 1'b0;

    int errors   = 0;
    int checks   = 0;
    bit check_en = 1'b0;

    // Model state: phase 0 = idle, 1 = requesting, 2 = in service.
    int m_mask  = ALL;
    int m_mode  = 0;
    int m_pend  = 0;
    int m_prev  = 0;
    int m_phase = 0;
    int m_vec   = 0;
    int m_irq   = 0;
    int m_dout  = 0;

    always #5 clk = ~clk;

    irq_controller #(
        .NIRQ (NIRQ),
        .VECW (VECW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (irq_in),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_din  (cfg_din),
        .cfg_dout (cfg_dout),
        .cpu_irq  (cpu_irq),
        .cpu_vec  (cpu_vec),
        .cpu_ack  (cpu_ack),
        .cpu_eoi  (cpu_eoi)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest_bit(input int v);
        for (int i = 0; i < NIRQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int elig, rise, clr, ackclr, nxt, rd, in_v;
        if (!rst) begin
            m_mask  <= ALL;
            m_mode  <= 0;
            m_pend  <= 0;
            m_prev  <= 0;
            m_phase <= 0;
            m_vec   <= 0;
            m_irq   <= 0;
            m_dout  <= 0;
        end else begin
            in_v = int'(irq_in);
            elig = m_pend & ~m_mask & ALL;
            case (cfg_addr)
                2'd0:    rd = m_mask;
                2'd1:    rd = m_pend;
                2'd2:    rd = m_mode;
                default: rd = (m_phase != 0 ? 32 : 0) + m_phase * 8 + (m_phase == 2 ? m_vec : 0);
            endcase
            ackclr = 0;
            if (m_phase == 0) begin
                if (elig != 0) begin
                    m_vec   <= lowest_bit(elig) + 1;
                    m_irq   <= 1;
                    m_phase <= 1;
                end
            end else if (m_phase == 1) begin
                if (((elig >> (m_vec - 1)) & 1) == 0) begin
                    m_irq   <= 0;
                    m_vec   <= 0;
                    m_phase <= 0;
                end else if (cpu_ack) begin
                    m_irq   <= 0;
                    m_phase <= 2;
                    if (((m_mode >> (m_vec - 1)) & 1) == 0) ackclr = 1 << (m_vec - 1);
                end
            end else if (cpu_eoi) begin
                m_vec   <= 0;
                m_phase <= 0;
            end
            rise = in_v & ~m_prev;
            clr  = ackclr | ((cfg_we && cfg_addr == 2'd1) ? int'(cfg_din) : 0);
            nxt  = 0;
            for (int i = 0; i < NIRQ; i++) begin
                if (m_mode[i]) nxt[i] = in_v[i];
                else           nxt[i] = rise[i] | (m_pend[i] & ~clr[i]);
            end
            m_pend <= nxt;
            m_prev <= in_v;
            m_dout <= rd;
            if (cfg_we && cfg_addr == 2'd0) m_mask <= int'(cfg_din) & ALL;
            if (cfg_we && cfg_addr == 2'd2) m_mode <= int'(cfg_din) & ALL;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model cpu_irq", int'(cpu_irq), m_irq);
            chk("model cpu_vec", int'(cpu_vec), m_vec);
            chk("model cfg_dout", int'(cfg_dout), m_dout);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = addr[1:0];
        cfg_din  = data[15:0];
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse(input int bits);
        irq_in = bits[NIRQ-1:0];
        step();
        irq_in = '0;
    endtask

    task automatic ack_eoi();
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        cpu_eoi = 1'b1;
        step();
        cpu_eoi = 1'b0;
    endtask

    task automatic wait_irq(input string name, input int budget);
        int n = 0;
        while (!cpu_irq && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!cpu_irq) begin
            errors++;
            $display("FAIL %s: cpu_irq=0 after %0d cycles, expected 1", name, budget);
        end
    endtask

    initial begin
        step(2);
        chk("reset cpu_irq", int'(cpu_irq), 0);
        chk("reset cpu_vec", int'(cpu_vec), 0);
        chk("reset cfg_dout", int'(cfg_dout), 0);
        rst      = 1'b1;
        check_en = 1'b1;

        // single edge source
        cfg_write(REG_MASK, 0);
        cfg_addr = REG_PENDING;
        pulse(32'h04);
        step();
        chk("single cpu_irq", int'(cpu_irq), 1);
        chk("single cpu_vec", int'(cpu_vec), 3);
        chk("single pending", int'(cfg_dout), 32'h04);
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        chk("ack cpu_irq", int'(cpu_irq), 0);
        step();
        chk("ack pending", int'(cfg_dout), 0);
        cfg_addr = REG_STATUS;
        step();
        chk("isr status", int'(cfg_dout), 32'h33);
        cpu_eoi = 1'b1;
        step();
        cpu_eoi = 1'b0;
        chk("eoi cpu_vec", int'(cpu_vec), 0);

        // priority
        pulse(32'h22);
        step();
        chk("prio first vec", int'(cpu_vec), 2);
        ack_eoi();
        wait_irq("prio second irq", 4);
        chk("prio second vec", int'(cpu_vec), 6);
        ack_eoi();

        // mask gating
        cfg_write(REG_MASK, 1);
        pulse(32'h01);
        cfg_addr = REG_PENDING;
        step(3);
        chk("masked cpu_irq", int'(cpu_irq), 0);
        chk("masked pending", int'(cfg_dout), 1);
        cfg_write(REG_MASK, 0);
        step();
        chk("unmask cpu_irq", int'(cpu_irq), 1);
        chk("unmask cpu_vec", int'(cpu_vec), 1);
        ack_eoi();

        // level mode
        cfg_write(REG_MODE, 32'h08);
        irq_in = 7'h08;
        wait_irq("level irq", 5);
        chk("level vec", int'(cpu_vec), 4);
        ack_eoi();
        wait_irq("level rerequest", 4);
        chk("level rerequest vec", int'(cpu_vec), 4);
        irq_in = '0;
        step(2);
        chk("level withdraw irq", int'(cpu_irq), 0);
        chk("level withdraw vec", int'(cpu_vec), 0);
        cfg_write(REG_MODE, 0);

        // set wins over ack clear
        pulse(32'h04);
        step();
        chk("collision vec", int'(cpu_vec), 3);
        cfg_addr = REG_PENDING;
        cpu_ack  = 1'b1;
        irq_in   = 7'h04;
        step();
        cpu_ack  = 1'b0;
        irq_in   = '0;
        step();
        chk("collision pending", int'(cfg_dout), 32'h04);
        cpu_eoi = 1'b1;
        step();
        cpu_eoi = 1'b0;
        wait_irq("collision rerequest", 4);
        chk("collision rerequest vec", int'(cpu_vec), 3);
        ack_eoi();

        // asynchronous reset while in service
        pulse(32'h10);
        step();
        cpu_ack = 1'b1;
        step();
        cpu_ack = 1'b0;
        chk("pre-reset isr vec", int'(cpu_vec), 5);
        #2 rst = 1'b0;
        #1;
        chk("async reset cpu_irq", int'(cpu_irq), 0);
        chk("async reset cpu_vec", int'(cpu_vec), 0);
        chk("async reset cfg_dout", int'(cfg_dout), 0);
        @(negedge clk);
        cfg_addr = REG_MASK;
        rst      = 1'b1;
        step();
        chk("post-reset mask", int'(cfg_dout), 32'h7F);
        cfg_addr = REG_PENDING;
        step();
        chk("post-reset pending", int'(cfg_dout), 0);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int k;
            if ($urandom_range(0, 3) == 0) begin
                k = int'($urandom_range(0, NIRQ - 1));
                irq_in[k] = ~irq_in[k];
            end
            cpu_ack  = ($urandom_range(0, 3) == 0);
            cpu_eoi  = ($urandom_range(0, 5) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_we   = ($urandom_range(0, 15) == 0);
            cfg_din  = 16'($urandom & $urandom);
            step();
        end
        cfg_we  = 1'b0;
        cpu_ack = 1'b0;
        cpu_eoi = 1'b0;
        step(2);
        check_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
